// File: rtl/polyvec_addsub_stream_if.sv
// polyvec_addsub_stream_if: control, input-beat and result-beat signals of the
// polynomial-vector add/subtract stream. The engine connects through the
// slave modport. The producer/consumer side connects through the master modport.
interface polyvec_addsub_stream_if #(
  parameter int W     = 32,
  parameter int LANES = 4
);
  logic               start;
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] a_in;
  logic [LANES*W-1:0] b_in;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_data;
  logic               out_poly_last;
  logic               out_last;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_data, out_poly_last, out_last, busy, done
  );

  modport slave (
    input  start, mode, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_data, out_poly_last, out_last, busy, done
  );
endinterface

// File: rtl/polyvec_addsub_stream.sv
// polyvec_addsub_stream: streams a K-polynomial vector pair, LANES coefficients
// per beat, and produces w = a + b (mode 0) or w = a - b (mode 1) through a
// single output register stage with valid/ready on both sides.
// Compile-time option: define POLYVEC_ADDSUB_REDUCE_EN to apply Dilithium
// reduce32 to every lane result. Otherwise results wrap to W bits.
module polyvec_addsub_stream #(
  parameter int K     = 6,
  parameter int N     = 256,
  parameter int W     = 32,
  parameter int LANES = 4,
  parameter int Q     = 8380417
) (
  input  logic clk,
  input  logic rst_n,
  polyvec_addsub_stream_if.slave bus
);
  localparam int BPP = N / LANES;
  localparam int BW  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int PW  = (K > 1) ? $clog2(K) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BPP - 1);
  localparam logic [PW-1:0] POLY_MAX = PW'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [PW-1:0]      poly_cnt_q, poly_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [LANES*W-1:0] out_data_q, out_data_d;
  logic               out_poly_last_q, out_poly_last_d;
  logic               out_last_q, out_last_d;

  logic               in_ready;
  logic               in_hs;
  logic               out_hs;
  logic               beat_wrap;
  logic               vec_end;
  logic [LANES*W-1:0] lane_res;
  logic [LANES-1:0]   unused_msb;
  logic signed [W:0]  lane_a [LANES];
  logic signed [W:0]  lane_b [LANES];
  logic signed [W:0]  lane_x [LANES];
  logic signed [W:0]  lane_r [LANES];

`ifdef POLYVEC_ADDSUB_REDUCE_EN
  localparam logic signed [W:0] RED_RND = (W+1)'(1 << 22);
  localparam logic signed [W:0] RED_Q   = (W+1)'(Q);
  logic signed [W:0]  lane_t [LANES];
`else
  localparam int unused_q = Q;
`endif

  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
  assign in_hs     = bus.in_valid && in_ready;
  assign out_hs    = out_valid_q && bus.out_ready;
  assign beat_wrap = (beat_cnt_q == BEAT_MAX);
  assign vec_end   = beat_wrap && (poly_cnt_q == POLY_MAX);

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_poly_last = out_poly_last_q;
  assign bus.out_last      = out_last_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);

  // Per-lane W+1-bit sum/difference, optionally reduced, then truncated to W bits
  always_comb begin
    lane_a     = '{default: '0};
    lane_b     = '{default: '0};
    lane_x     = '{default: '0};
    lane_r     = '{default: '0};
`ifdef POLYVEC_ADDSUB_REDUCE_EN
    lane_t     = '{default: '0};
`endif
    lane_res   = '0;
    unused_msb = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a[i] = {bus.a_in[W*i+W-1], bus.a_in[W*i +: W]};
      lane_b[i] = {bus.b_in[W*i+W-1], bus.b_in[W*i +: W]};
      lane_x[i] = mode_q ? (lane_a[i] - lane_b[i]) : (lane_a[i] + lane_b[i]);
`ifdef POLYVEC_ADDSUB_REDUCE_EN
      lane_t[i] = (lane_x[i] + RED_RND) >>> 23;
      lane_r[i] = lane_x[i] - lane_t[i] * RED_Q;
`else
      lane_r[i] = lane_x[i];
`endif
      lane_res[W*i +: W] = lane_r[i][W-1:0];
      unused_msb[i]      = lane_r[i][W];
    end
  end

  // Job sequencing, beat/polynomial counting and output register loading
  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    beat_cnt_d      = beat_cnt_q;
    poly_cnt_d      = poly_cnt_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_poly_last_d = out_poly_last_q;
    out_last_d      = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_RUN;
          mode_d     = bus.mode;
          beat_cnt_d = '0;
          poly_cnt_d = '0;
        end
      end
      S_RUN:   if (in_hs && vec_end) state_d = S_DRAIN;
      S_DRAIN: if (out_hs && out_last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (in_hs) begin
      if (beat_wrap) begin
        beat_cnt_d = '0;
        poly_cnt_d = (poly_cnt_q == POLY_MAX) ? '0 : poly_cnt_q + 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
      out_valid_d     = 1'b1;
      out_data_d      = lane_res;
      out_poly_last_d = beat_wrap;
      out_last_d      = vec_end;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // State, counters and output stage registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      mode_q          <= 1'b0;
      beat_cnt_q      <= '0;
      poly_cnt_q      <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_poly_last_q <= 1'b0;
      out_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      beat_cnt_q      <= beat_cnt_d;
      poly_cnt_q      <= poly_cnt_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_poly_last_q <= out_poly_last_d;
      out_last_q      <= out_last_d;
    end
  end
endmodule

// File: tb/tb_polyvec_addsub_stream.sv
// tb_polyvec_addsub_stream: table-driven full-vector jobs with hand-computed
// lane results, plus stress jobs (random in_valid gaps, random out_ready,
// mid-job start with flipped mode) and a mid-job reset abort.
module tb_polyvec_addsub_stream;
  localparam int K     = 6;
  localparam int N     = 256;
  localparam int W     = 32;
  localparam int LANES = 4;
  localparam int BPP   = N / LANES;
  localparam int BEATS = K * BPP;
  localparam int DW    = LANES * W;
  localparam int LIMIT = 6000;

  typedef struct {
    string          name;
    logic           mode;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  exp;
    bit             preload;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vecs[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  polyvec_addsub_stream_if #(.W(W), .LANES(LANES)) bus ();

  polyvec_addsub_stream #(
    .K(K), .N(N), .W(W), .LANES(LANES), .Q(8380417)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [W-1:0] v);
    return {LANES{v}};
  endfunction

  // Stress data stays far below 2^22 so reduce32 leaves it unchanged
  function automatic logic [DW-1:0] stressA(input int idx);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[W*i +: W] = W'((idx * LANES + i) * 3);
    return r;
  endfunction

  function automatic logic [DW-1:0] stressB(input int idx);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[W*i +: W] = W'(7 * i + idx);
    return r;
  endfunction

  function automatic logic [DW-1:0] stressExp(input logic m, input int idx);
    logic [DW-1:0] a, b, r;
    a = stressA(idx);
    b = stressB(idx);
    for (int i = 0; i < LANES; i++)
      r[W*i +: W] = m ? (a[W*i +: W] - b[W*i +: W]) : (a[W*i +: W] + b[W*i +: W]);
    return r;
  endfunction

  task automatic addVec(input string name, input logic m, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] e, input bit pre);
    vec_t v;
    v.name = name; v.mode = m; v.a = a; v.b = b; v.exp = e; v.preload = pre;
    vecs.push_back(v);
  endtask

  task automatic driveBeat(input logic m, input logic [DW-1:0] a_c, input logic [DW-1:0] b_c,
                           input bit stress, input int sent);
    if (sent < BEATS) begin
      bus.in_valid = stress ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.a_in     = stress ? stressA(sent) : a_c;
      bus.b_in     = stress ? stressB(sent) : b_c;
    end else begin
      bus.in_valid = stress;
      bus.a_in     = rep(32'hDEAD);
      bus.b_in     = rep(32'hBEEF);
    end
    bus.out_ready = stress ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic applyStimulus(input string name, input logic m, input logic [DW-1:0] a_c,
                               input logic [DW-1:0] b_c, input logic [DW-1:0] exp_c,
                               input bit stress, input bit preload, input bit restart_mid,
                               input int abort_at);
    int sent, recv, cyc, first_in, last_out;
    int data_err, flag_err, stab_err, early_done;
    bit finished, restarted, prev_stall;
    logic [DW-1:0] prev_data, exp_beat;
    logic prev_pl, prev_l;
    exp_q.delete();
    sent = 0; recv = 0; cyc = 0; first_in = -1; last_out = 0;
    data_err = 0; flag_err = 0; stab_err = 0; early_done = 0;
    finished = 0; restarted = 0; prev_stall = 0;
    prev_data = '0; prev_pl = 0; prev_l = 0;

    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.out_ready = 1'b1;
    bus.in_valid  = preload;
    bus.a_in      = stress ? stressA(0) : a_c;
    bus.b_in      = stress ? stressB(0) : b_c;
    @(negedge clk);
    if (preload) checkOutput({name, " in_ready in IDLE"}, DW'(bus.in_ready), '0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = ~m;
    driveBeat(m, a_c, b_c, stress, sent);

    while (!finished && cyc < LIMIT) begin
      @(negedge clk);
      if (cyc == 0)
        checkOutput({name, " busy,in_ready after start"}, DW'({bus.busy, bus.in_ready}), DW'(2'b11));
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data ||
                         bus.out_poly_last !== prev_pl || bus.out_last !== prev_l))
        stab_err++;
      if (bus.done) early_done++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) data_err++;
        else begin
          exp_beat = exp_q.pop_front();
          if (bus.out_data !== exp_beat) data_err++;
        end
        if (bus.out_poly_last !== ((recv % BPP) == BPP - 1)) flag_err++;
        if (bus.out_last !== (recv == BEATS - 1)) flag_err++;
        recv++;
        last_out = cyc;
        if (recv == BEATS) finished = 1;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(stress ? stressExp(m, sent) : exp_c);
        if (first_in < 0) first_in = cyc;
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_pl    = bus.out_poly_last;
      prev_l     = bus.out_last;
      if (finished) break;
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && sent == abort_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput({name, " ctrl after reset"},
                    DW'({bus.in_ready, bus.out_valid, bus.out_poly_last, bus.out_last, bus.busy, bus.done}), '0);
        checkOutput({name, " out_data after reset"}, bus.out_data, '0);
        bus.in_valid = 1'b0;
        return;
      end
      bus.start = restart_mid && !restarted && (sent == 50);
      if (bus.start) restarted = 1;
      driveBeat(m, a_c, b_c, stress, sent);
    end

    checkOutput({name, " completed"}, DW'(finished), DW'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
    checkOutput({name, " done,busy after last"}, DW'({bus.done, bus.busy}), DW'(2'b11));
    @(negedge clk);
    checkOutput({name, " done,busy idle"}, DW'({bus.done, bus.busy}), DW'(2'b00));
    checkOutput({name, " beats out"}, DW'(recv), DW'(BEATS));
    checkOutput({name, " beats in"}, DW'(sent), DW'(BEATS));
    checkOutput({name, " data errors"}, DW'(data_err), '0);
    checkOutput({name, " last flag errors"}, DW'(flag_err), '0);
    checkOutput({name, " stall stability errors"}, DW'(stab_err), '0);
    checkOutput({name, " early done"}, DW'(early_done), '0);
    if (!stress)
      checkOutput({name, " cycles first-in to last-out"}, DW'(last_out - first_in), DW'(BEATS));
  endtask

  initial begin
`ifdef POLYVEC_ADDSUB_REDUCE_EN
    addVec("red add q",     1'b0, rep(32'd8380417), rep(32'd0), rep(32'd0), 1'b0);
    addVec("red sub 0-1",   1'b1, rep(32'd0), rep(32'd1), rep(32'hFFFFFFFF), 1'b1);
    addVec("red add 2q-2",  1'b0, rep(32'd8380416), rep(32'd8380416), rep(32'hFFFFFFFE), 1'b0);
    addVec("red add mixed", 1'b0, {32'd8380417, 32'd5, 32'd0, 32'd8380416},
           {32'd0, 32'd3, 32'd0, 32'd8380416}, {32'd0, 32'd8, 32'd0, 32'hFFFFFFFE}, 1'b0);
`else
    addVec("add 5+3",       1'b0, rep(32'd5), rep(32'd3), rep(32'd8), 1'b0);
    addVec("sub 0-1",       1'b1, rep(32'd0), rep(32'd1), rep(32'hFFFFFFFF), 1'b1);
    addVec("sub wrap",      1'b1, rep(32'h7FFFFFFF), rep(32'hFFFFFFFF), rep(32'h80000000), 1'b0);
    addVec("add lanes",     1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
           {32'd44, 32'd33, 32'd22, 32'd11}, 1'b0);
    addVec("sub lanes",     1'b1, {32'd100, 32'd0, 32'h7FFFFFFF, 32'h80000000},
           {32'd1, 32'd5, 32'hFFFFFFFF, 32'd1}, {32'd99, 32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF}, 1'b0);
    addVec("add overflow",  1'b0, rep(32'h7FFFFFFF), rep(32'd1), rep(32'h80000000), 1'b0);
`endif

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;
    #2;
    checkOutput("reset ctrl",
                DW'({bus.in_ready, bus.out_valid, bus.out_poly_last, bus.out_last, bus.busy, bus.done}), '0);
    checkOutput("reset out_data", bus.out_data, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, vecs[i].preload, 1'b0, -1);

    applyStimulus("stress add", 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1, -1);
    applyStimulus("stress sub", 1'b1, '0, '0, '0, 1'b1, 1'b1, 1'b1, -1);

    applyStimulus("abort", 1'b0, rep(32'd5), rep(32'd3), rep(32'd8), 1'b0, 1'b0, 1'b0, 100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus("after abort", 1'b0, rep(32'd5), rep(32'd3), rep(32'd8), 1'b0, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/polyvec_addsub_stream.md
# polyvec_addsub_stream

Sequential, parametrised polynomial-vector add/subtract engine for the Dilithium datapath. It streams a K-polynomial vector pair through LANES coefficients per beat under valid/ready handshakes. Mode (add or subtract) is selected per vector. Optional Dilithium reduce32 on each result is selected at compile time. It is the streaming successor of the flat combinational vector subtractor and sits between the coefficient RAM readers and the writer in the signing and verification datapaths.

## Interface
- `K`, 6, polynomials per vector
- `N`, 256, coefficients per polynomial; must be divisible by `LANES`
- `W`, 32, signed coefficient width
- `LANES`, 4, coefficients per beat; power of two
- `Q`, 8380417, modulus; used only when reduction is compiled in
- `clk` input 1 — rising-edge clock
- `rst_n` input 1 — asynchronous, active-low reset
- `start` input 1 — one-cycle pulse that starts a vector job; ignored unless IDLE
- `mode` input 1 — sampled on `start`: 0 gives w=a+b, 1 gives w=a−b
- `in_valid` input 1 — a/b beat present
- `in_ready` output 1 — beat accepted when `in_valid && in_ready`
- `a_in` input LANES*W — lane i at bits [W*i+W−1 : W*i], signed
- `b_in` input LANES*W — same packing as `a_in`
- `out_valid` output 1 — result beat present
- `out_ready` input 1 — downstream accepts the result beat
- `out_data` output LANES*W — result lanes, same packing
- `out_poly_last` output 1 — current output beat is the last beat of a polynomial
- `out_last` output 1 — current output beat is the last beat of the vector
- `busy` output 1 — high whenever not IDLE
- `done` output 1 — one-cycle pulse when the job completes

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`. `mode` is latched; both counters clear.
  - RUN → DRAIN on the input handshake of beat K*N/LANES−1.
  - DRAIN → DONE on the output handshake of the beat with `out_last=1`.
  - DONE → IDLE unconditionally after 1 cycle.
- Counters:
  - `beat_cnt` counts 0..N/LANES−1. It increments on each input handshake and wraps to 0 at the end of each polynomial.
  - `poly_cnt` counts 0..K−1. It increments when `beat_cnt` wraps.
  - `out_poly_last` and `out_last` are registered with the data beat they describe.
- Arithmetic (per lane):
  - Sum or difference is computed in W+1 bits.
  - Without reduction, the result is truncated to W bits (two's-complement wrap).
- One output register stage:
  - `in_ready = (state==RUN) && (!out_valid || out_ready)`.
  - An input handshake loads `out_data` and sets `out_valid`.
  - An output handshake with no simultaneous input handshake clears `out_valid`.
  - A simultaneous input and output handshake replaces the data with `out_valid` staying 1.
- `in_ready` is 0 in IDLE, DRAIN and DONE. Beats offered there are not consumed.
- A `start` pulse while `busy` is ignored. `mode` is not re-sampled mid-job.
- An `in_valid` beat that arrives before `start` stays pending and is accepted in the first RUN cycle.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_poly_last`=0, `out_last`=0, `busy`=0, `done`=0. The state machine resets to IDLE and both counters reset to 0.
- Reset mid-job aborts immediately. Any partial result is discarded and no `done` pulse is produced.
- `start` at cycle t gives `busy`=1 and `in_ready`=1 at t+1 (when `out_valid`=0).
- Latency: the input handshake at cycle t gives `out_valid`=1 with the result at t+1.
- Sustained throughput is 1 beat per cycle with `out_ready` held at 1. A 6×256×4 job completes in 384 beats plus 1 cycle of latency.
- `done` asserts the cycle after the final output handshake. `busy` drops one cycle later.
- Output back-pressure: `out_data`, `out_poly_last` and `out_last` stay stable while `out_valid && !out_ready`.

## Configuration
- `POLYVEC_ADDSUB_REDUCE_EN` defined:
  - Each W+1-bit lane result x is replaced by the reduce32 value x − t·Q, where t = (x + 2^22) >>> 23 (arithmetic shift).
  - The reduction is combinational inside the same stage, so latency is unchanged.
- Macro undefined: results are plain wrapped a±b with no modular reduction, and `Q` is unused.

## Test plan
- Add, no reduction, K=6, LANES=4: all a=5, b=3 → every lane 8. There are 384 output beats. `out_poly_last` fires on beats 63, 127, … 383, `out_last` only on beat 383, and `done` pulses once.
- Subtract, no reduction: a=0, b=1 → lanes 0xFFFFFFFF. With a=0x7FFFFFFF and b=0xFFFFFFFF → 0x80000000 (wrap).
- With `POLYVEC_ADDSUB_REDUCE_EN`, add a=8380417, b=0 → 0. Subtract a=0, b=1 → −1. Add a=8380416, b=8380416 → 16760832 − 2·8380417 = −2.
- Back-pressure: `out_ready` toggles 0/1 pseudo-randomly and `in_valid` gaps are random. Require no lost or duplicated beats, output data held stable while stalled, and output order equal to input order.
- `start` pulsed again mid-job with `mode` flipped: ignored, and all results keep the original mode.
- `rst_n` low at beat 100: all outputs return to reset values within the same cycle. A new `start` after release produces a full, correct 384-beat job.
